wb_counter_if: RTL and testbench

WB_COUNTER_IF -- requirements
Module: wb_counter_if

---
 rtl/wb_counter_pkg.sv | 26 ++
 rtl/wb_timeout_ctr.sv | 38 +++
 rtl/wb_counter_if.sv | 165 ++++++++++++++++
 tb/tb_wb_counter_if.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_counter_pkg.sv
// Shared definitions for the Wishbone counter interface.
//   - register offsets (word select, wbs_adr_i[3:2])
//   - CTRL / STATUS bit positions
//   - FSM state type and encodings
package wb_counter_pkg;

    localparam int unsigned WB_AW   = 32;
    localparam int unsigned WB_DW   = 32;
    localparam int unsigned WB_SELW = 4;
    localparam int unsigned TMO_W   = 8;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_LOAD   = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int unsigned CTRL_ENABLE_BIT    = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT    = 1;
    localparam int unsigned STATUS_TIMEOUT_BIT = 0;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_FWD  = 2'd1;
    localparam state_t ST_ACK  = 2'd2;

endpackage

// File: rtl/wb_timeout_ctr.sv
// Cycle counter bounding the wait for the downstream counter's ready.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   load_i    : restart counting (first waiting cycle follows)
//   en_i      : count one waiting cycle
//   expired_o : registered; high during the TIMEOUT-th waiting cycle
module wb_timeout_ctr
    import wb_counter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TMO_W-1:0] cnt_q;
    logic             hit_q;

    // hit_q is precomputed one cycle ahead so the flag comes from a register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            hit_q <= 1'b0;
        end else if (load_i) begin
            cnt_q <= '0;
            hit_q <= (TIMEOUT == 1);
        end else if (en_i) begin
            cnt_q <= cnt_q + TMO_W'(1);
            hit_q <= ((cnt_q + TMO_W'(1)) == TMO_W'(TIMEOUT - 1));
        end
    end

    assign expired_o = hit_q;

endmodule

// File: rtl/wb_counter_if.sv
// Wishbone classic slave fronting a counter: CTRL/LOAD/COUNT/STATUS window,
// LOAD writes forwarded downstream with a ready handshake and a timeout.
//   wb_clk_i, wb_rst_i         : clock, synchronous active-high reset
//   wbs_*_i / wbs_ack_o/dat_o  : Wishbone slave port
//   cnt_valid_o/wstrb_o/wdata_o: downstream write request, cnt_ready_i accepts
//   cnt_count_i                : live count (COUNT register)
//   cnt_enable_o, irq_o        : CTRL.enable, timeout interrupt
module wb_counter_if
    import wb_counter_pkg::*;
#(
    parameter int unsigned BITS      = 16,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [WB_SELW-1:0] wbs_sel_i,
    input  logic [WB_AW-1:0]   wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [WB_DW-1:0]   wbs_dat_o,
    output logic               cnt_valid_o,
    output logic [WB_SELW-1:0] cnt_wstrb_o,
    output logic [BITS-1:0]    cnt_wdata_o,
    input  logic               cnt_ready_i,
    input  logic [BITS-1:0]    cnt_count_i,
    output logic               cnt_enable_o,
    output logic               irq_o
);

    state_t             state_q, state_d;
    logic [1:0]         ctrl_q, ctrl_d;
    logic [BITS-1:0]    load_q, load_d;
    logic               status_q, status_d;
    logic               ack_q, ack_d;
    logic [WB_DW-1:0]   rdat_q, rdat_d;
    logic               valid_q, valid_d;
    logic [BITS-1:0]    wdata_q, wdata_d;
    logic [WB_SELW-1:0] wstrb_q, wstrb_d;

    logic               req_c, match_c, load_wr_c;
    logic [1:0]         reg_sel_c;
    logic [WB_DW-1:0]   rdata_c;
    logic               tmo_load_c, tmo_en_c, tmo_expired;
    logic               unused_c;

    assign req_c     = wbs_cyc_i & wbs_stb_i;
    assign match_c   = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel_c = wbs_adr_i[3:2];
    assign load_wr_c = match_c & wbs_we_i & (reg_sel_c == REG_LOAD) & (|wbs_sel_i);
    assign unused_c  = ^{wbs_adr_i[1:0], wbs_dat_i};

    // Read mux; out-of-window reads return zero
    always_comb begin
        rdata_c = '0;
        if (match_c) begin
            case (reg_sel_c)
                REG_CTRL:   rdata_c = WB_DW'(ctrl_q);
                REG_LOAD:   rdata_c = WB_DW'(load_q);
                REG_COUNT:  rdata_c = WB_DW'(cnt_count_i);
                REG_STATUS: rdata_c = WB_DW'(status_q);
            endcase
        end
    end

    // Next-state and register-update logic
    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        load_d     = load_q;
        status_d   = status_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdat_d     = '0;
        tmo_load_c = 1'b0;
        tmo_en_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (load_wr_c) begin
                        state_d    = ST_FWD;
                        tmo_load_c = 1'b1;
                        wdata_d    = wbs_dat_i[BITS-1:0];
                        wstrb_d    = wbs_sel_i;
                        for (int i = 0; i < int'(BITS); i++) begin
                            if (wbs_sel_i[i/8]) load_d[i] = wbs_dat_i[i];
                        end
                    end else begin
                        state_d = ST_ACK;
                        if (wbs_we_i && match_c) begin
                            // CTRL enable/irq_en both live in byte 0
                            if (reg_sel_c == REG_CTRL && wbs_sel_i[0])
                                ctrl_d = wbs_dat_i[1:0];
                            if (reg_sel_c == REG_STATUS && wbs_sel_i[0] &&
                                wbs_dat_i[STATUS_TIMEOUT_BIT])
                                status_d = 1'b0;
                        end
                        if (!wbs_we_i) rdat_d = rdata_c;
                    end
                end
            end
            ST_FWD: begin
                tmo_en_c = 1'b1;
                // ready has priority over a coincident expiry
                if (cnt_ready_i) begin
                    state_d = ST_ACK;
                end else if (tmo_expired) begin
                    state_d  = ST_ACK;
                    status_d = 1'b1;
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        ack_d   = (state_d == ST_ACK);
        valid_d = (state_d == ST_FWD);
    end

    // State and output registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            load_q   <= '0;
            status_q <= 1'b0;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
            valid_q  <= 1'b0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            load_q   <= load_d;
            status_q <= status_d;
            ack_q    <= ack_d;
            rdat_q   <= rdat_d;
            valid_q  <= valid_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
        end
    end

    wb_timeout_ctr #(
        .TIMEOUT(TIMEOUT)
    ) u_tmo (
        .clk_i    (wb_clk_i),
        .rst_i    (wb_rst_i),
        .load_i   (tmo_load_c),
        .en_i     (tmo_en_c),
        .expired_o(tmo_expired)
    );

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = rdat_q;
    assign cnt_valid_o  = valid_q;
    assign cnt_wdata_o  = wdata_q;
    assign cnt_wstrb_o  = wstrb_q;
    assign cnt_enable_o = ctrl_q[CTRL_ENABLE_BIT];
    assign irq_o        = status_q & ctrl_q[CTRL_IRQ_EN_BIT];

endmodule

// File: tb/tb_wb_counter_if.sv
// Self-checking bench for wb_counter_if: reference register model feeds a
// scoreboard queue of expected bus responses, popped when the ack appears.
module tb_wb_counter_if;

    localparam int unsigned BITS = 16;
    localparam int unsigned TMO  = 15;
    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk, rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic        valid;
    logic [3:0]  wstrb;
    logic [15:0] wdata;
    logic        ready;
    logic [15:0] count;
    logic        enable, irq;

    wb_counter_if #(
        .BITS     (BITS),
        .BASE_ADDR(BASE),
        .TIMEOUT  (TMO)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (cyc),
        .wbs_stb_i   (stb),
        .wbs_we_i    (we),
        .wbs_sel_i   (sel),
        .wbs_adr_i   (adr),
        .wbs_dat_i   (dat_i),
        .wbs_ack_o   (ack),
        .wbs_dat_o   (dat_o),
        .cnt_valid_o (valid),
        .cnt_wstrb_o (wstrb),
        .cnt_wdata_o (wdata),
        .cnt_ready_i (ready),
        .cnt_count_i (count),
        .cnt_enable_o(enable),
        .irq_o       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] dat;
        int          vcyc;
        logic        fwd;
        logic [15:0] wdata;
        logic [3:0]  wstrb;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    // reference model of the register file
    logic [1:0]  m_ctrl;
    logic [15:0] m_load;
    logic        m_status;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic in_win(input logic [31:0] a);
        return a[31:4] == BASE[31:4];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [1:0] r;
        r = a[3:2];
        if (!in_win(a)) return 32'h0;
        case (r)
            2'd0:    return {30'h0, m_ctrl};
            2'd1:    return {16'h0, m_load};
            2'd2:    return {16'h0, count};
            default: return {31'h0, m_status};
        endcase
    endfunction

    // One bus access; ready_at = FWD cycle on which ready is raised (0 = never)
    task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int ready_at);
        exp_t e, got_e;
        logic [1:0] r;
        bit tmo, got_ack;
        int lat, vcyc;
        logic [31:0] ack_dat;
        r = a[3:2];
        e.fwd   = w && in_win(a) && (r == 2'd1) && (s != 4'h0);
        e.dat   = w ? 32'h0 : model_read(a);
        e.wdata = d[15:0];
        e.wstrb = s;
        tmo     = !(ready_at >= 1 && ready_at <= int'(TMO));
        e.vcyc  = e.fwd ? (tmo ? int'(TMO) : ready_at) : 0;
        sb_q.push_back(e);
        if (w && in_win(a)) begin
            if (r == 2'd0 && s[0]) m_ctrl = d[1:0];
            if (r == 2'd3 && s[0] && d[0]) m_status = 1'b0;
            if (e.fwd) begin
                for (int i = 0; i < 16; i++) if (s[i/8]) m_load[i] = d[i];
                if (tmo) m_status = 1'b1;
            end
        end
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        lat = 0; vcyc = 0; got_ack = 0; ack_dat = 32'h0;
        while (!got_ack && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (valid) begin
                vcyc++;
                ready = (vcyc == ready_at);
            end else begin
                ready = 1'b0;
            end
            if (ack) begin
                got_ack = 1;
                ack_dat = dat_o;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0;
        got_e = sb_q.pop_front();
        if (!got_ack) begin
            check("ack_seen", 32'h0, 32'h1);
        end else begin
            // master samples ack on the edge after it appears
            check("ack_lat", 32'(lat + 1), 32'(got_e.vcyc + 2));
            check("rdata", ack_dat, got_e.dat);
            if (got_e.fwd) begin
                check("valid_cycles", 32'(vcyc), 32'(got_e.vcyc));
                check("fwd_wdata", {16'h0, wdata}, {16'h0, got_e.wdata});
                check("fwd_wstrb", {28'h0, wstrb}, {28'h0, got_e.wstrb});
            end
        end
        @(posedge clk);
        @(negedge clk);
        check("ack_one_cycle", {31'h0, ack}, 32'h0);
        check("dat_after_ack", dat_o, 32'h0);
        check("enable", {31'h0, enable}, {31'h0, m_ctrl[0]});
        check("irq", {31'h0, irq}, {31'h0, m_status & m_ctrl[1]});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = 32'h0; dat_i = 32'h0; ready = 1'b0; count = 16'h0;
        m_ctrl = 2'b0; m_load = 16'h0; m_status = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", dat_o, 32'h0);
        check("rst_valid", {31'h0, valid}, 32'h0);
        check("rst_wdata", {16'h0, wdata}, 32'h0);
        check("rst_wstrb", {28'h0, wstrb}, 32'h0);
        check("rst_en_irq", {30'h0, enable, irq}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // CTRL write/readback
        wb_access(1'b1, BASE + 32'h0, 32'h0000_0003, 4'hF, 0);
        wb_access(1'b0, BASE + 32'h0, 32'h0, 4'hF, 0);
        // LOAD forwarded, ready on 3rd FWD cycle
        wb_access(1'b1, BASE + 32'h4, 32'h0000_1234, 4'hF, 3);
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);
        wb_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0);
        // LOAD with no ready: timeout, irq, then W1C
        wb_access(1'b1, BASE + 32'h4, 32'h0000_BEEF, 4'hF, 0);
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);
        wb_access(1'b1, BASE + 32'hC, 32'h0000_0001, 4'h1, 0);
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);
        // out-of-window read/write, COUNT read
        wb_access(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0);
        wb_access(1'b1, BASE + 32'h10, 32'h0, 4'hF, 0);
        count = 16'h0066;
        wb_access(1'b0, BASE + 32'h8, 32'h0, 4'hF, 0);
        // ready on the final allowed cycle wins; one cycle later times out
        wb_access(1'b1, BASE + 32'h4, 32'h0000_0F0F, 4'hF, int'(TMO));
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);
        wb_access(1'b1, BASE + 32'h4, 32'h0000_00AA, 4'hF, int'(TMO) + 1);
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);
        wb_access(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 4'h1, 0);
        // byte-lane LOAD, sel=0 LOAD (no forward), CTRL with sel=0 and partial
        wb_access(1'b1, BASE + 32'h4, 32'hABCD_5678, 4'h2, 1);
        wb_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0);
        wb_access(1'b1, BASE + 32'h4, 32'h0000_FFFF, 4'h0, 0);
        wb_access(1'b1, BASE + 32'h0, 32'h0000_0000, 4'h0, 0);
        wb_access(1'b1, BASE + 32'h0, 32'h0000_0002, 4'h1, 0);
        wb_access(1'b0, BASE + 32'h0, 32'h0, 4'hF, 0);

        // reset in the middle of a forwarded write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h4;
        dat_i = 32'h0000_7777; sel = 4'hF;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("pre_rst_valid", {31'h0, valid}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        check("mid_rst_ack", {31'h0, ack}, 32'h0);
        check("mid_rst_valid", {31'h0, valid}, 32'h0);
        check("mid_rst_wdata", {16'h0, wdata}, 32'h0);
        check("mid_rst_en_irq", {30'h0, enable, irq}, 32'h0);
        m_ctrl = 2'b0; m_load = 16'h0; m_status = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_noack", {31'h0, ack}, 32'h0);
        wb_access(1'b0, BASE + 32'h0, 32'h0, 4'hF, 0);
        wb_access(1'b0, BASE + 32'h4, 32'h0, 4'hF, 0);
        wb_access(1'b0, BASE + 32'hC, 32'h0, 4'hF, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
